// File: rtl/hazard_pkg.sv
// Shared constants and the stage-record type for the hazard/forwarding controller.
package hazard_pkg;

  localparam int REG_W   = 5;
  localparam int NUM_STG = 3;
  localparam int NUM_SRC = 2;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_LDSTALL = 2'b01;
  localparam logic [1:0] ST_FREEZE  = 2'b10;

  // Operand source a match in each stage selects. A WB match maps to the
  // register file because the register file is write-first.
  localparam logic [NUM_STG-1:0][1:0] STG_FWD_CODE = {FWD_RF, FWD_WB, FWD_MEM};

  // Stages whose load can still cause a load-use stall.
  localparam logic [NUM_STG-1:0] LU_STG_MASK = 3'b001;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_rec_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request and EX control response bundle for hazard_fwd_ctrl.
interface hazard_fwd_ctrl_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] id_rs_i;
  logic [REG_W-1:0] id_rt_i;
  logic             id_uses_rt_i;
  logic [REG_W-1:0] id_rd_i;
  logic             id_regwrite_i;
  logic             id_memread_i;
  logic             id_valid_i;
  logic             flush_i;
  logic             mdu_busy_i;

  logic [1:0]       fwd_a_o;
  logic [1:0]       fwd_b_o;
  logic             stall_o;
  logic             bubble_o;
  logic [1:0]       state_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, id_rd_i, id_regwrite_i,
           id_memread_i, id_valid_i, flush_i, mdu_busy_i,
    input  fwd_a_o, fwd_b_o, stall_o, bubble_o, state_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, id_rd_i, id_regwrite_i,
           id_memread_i, id_valid_i, flush_i, mdu_busy_i,
    output fwd_a_o, fwd_b_o, stall_o, bubble_o, state_o
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record; a bubble keeps rd but drops its side effects.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic       clr,
  input  stage_rec_t d,
  output stage_rec_t q
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)  q <= '0;
    else if (en) q <= clr ? stage_rec_t'{rd: d.rd, regwrite: 1'b0, memread: 1'b0} : d;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, MDU freeze and EX operand-forward selection for a 5-stage pipe.
module hazard_fwd_ctrl
  import hazard_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  hazard_fwd_ctrl_if.slave bus
);

  logic [1:0]                        state_q, state_d;
  stage_rec_t [NUM_STG-1:0]          rec_q, rec_d;
  logic [NUM_STG-1:0]                rec_clr;
  logic [NUM_SRC-1:0][REG_W-1:0]     src;
  logic [NUM_SRC-1:0]                src_used;
  logic [NUM_SRC-1:0][NUM_STG-1:0]   match;
  logic [NUM_SRC-1:0][1:0]           fwd_d, fwd_q;
  logic                              lu_any, load_use, hold, lu_stall, advance, ex_bubble;

  assign src      = {bus.id_rt_i, bus.id_rs_i};
  assign src_used = {bus.id_uses_rt_i, 1'b1};

  // Per source, per stage: register-name match; forward from the newest hit.
  always_comb begin
    match = '0;
    fwd_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = 0; s < NUM_STG; s++)
        match[i][s] = src_used[i] && (rec_q[s].rd != '0) && (rec_q[s].rd == src[i]);
      fwd_d[i] = FWD_RF;
      for (int s = NUM_STG-1; s >= 0; s--)
        if (match[i][s] && rec_q[s].regwrite) fwd_d[i] = STG_FWD_CODE[s];
    end
  end

  always_comb begin
    lu_any = 1'b0;
    for (int s = 0; s < NUM_STG; s++)
      if (LU_STG_MASK[s] && rec_q[s].memread && (|{match[1][s], match[0][s]}))
        lu_any = 1'b1;
  end

  assign load_use  = (state_q == ST_RUN) && bus.id_valid_i && !bus.flush_i && lu_any;
  // A busy MDU freezes immediately, before any load-use bubble is inserted.
  assign hold      = bus.mdu_busy_i || (state_q == ST_FREEZE);
  assign lu_stall  = !hold && load_use;
  assign advance   = !hold;
  assign ex_bubble = lu_stall || bus.flush_i || !bus.id_valid_i;

  always_comb begin
    rec_d[STG_EX] = stage_rec_t'{rd:       bus.id_rd_i,
                                 regwrite: bus.id_regwrite_i,
                                 memread:  bus.id_memread_i};
    for (int s = 1; s < NUM_STG; s++) rec_d[s] = rec_q[s-1];
    rec_clr         = '0;
    rec_clr[STG_EX] = ex_bubble;
  end

  for (genvar g = 0; g < NUM_STG; g++) begin : g_stage
    hazard_stage_reg u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en    (advance),
      .clr   (rec_clr[g]),
      .d     (rec_d[g]),
      .q     (rec_q[g])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.mdu_busy_i)  state_d = ST_FREEZE;
        else if (load_use)   state_d = ST_LDSTALL;
      end
      ST_LDSTALL: state_d = bus.mdu_busy_i ? ST_FREEZE : ST_RUN;
      ST_FREEZE:  state_d = bus.mdu_busy_i ? ST_FREEZE : ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (advance) fwd_q <= ex_bubble ? '0 : fwd_d;
    end
  end

  assign bus.fwd_a_o  = fwd_q[0];
  assign bus.fwd_b_o  = fwd_q[1];
  // Reset also masks the combinational handshake outputs.
  assign bus.stall_o  = rst_i && (hold || lu_stall);
  assign bus.bubble_o = rst_i && lu_stall;
  assign bus.state_o  = state_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have one clock, clk_i (input, 1 bit), rising-edge.
REQ-002 The block SHALL have rst_i (input, 1 bit): asynchronous, active-low reset.
REQ-003 Inputs SHALL be:
- id_rs_i (5): ID-stage source register A.
- id_rt_i (5): ID-stage source register B.
- id_uses_rt_i (1): ID instruction reads rt; 0 when ALUSrc selects the immediate.
- id_rd_i (5): ID destination register.
- id_regwrite_i (1): ID instruction writes the register file.
- id_memread_i (1): ID instruction is a load.
- id_valid_i (1): ID slot holds a real instruction.
- flush_i (1): taken branch; squash the ID slot.
- mdu_busy_i (1): multi-cycle unit busy; freeze the pipeline.
REQ-004 Outputs SHALL be:
- fwd_a_o (2), fwd_b_o (2): select codes for the two 32-bit 4-to-1 operand muxes in EX.
- stall_o (1): hold PC and IF/ID.
- bubble_o (1): zero control in ID/EX.
- state_o (2): current FSM state.

Function
REQ-005 Forward codes SHALL be: 00 register file (data1), 01 WB result (data2), 10 MEM result (data3); 11 is never driven.
REQ-006 The block SHALL keep registered stage records EX, MEM and WB. Each record holds rd, regwrite and memread.
REQ-007 On each advance, records SHALL shift: ID->EX, EX->MEM, MEM->WB.
- EX loads regwrite=0 and memread=0 when bubble_o, flush_i or !id_valid_i.
REQ-008 fwd_a_o and fwd_b_o SHALL be registered.
- They are computed on the advance edge for the instruction entering EX.
- They are valid for the whole cycle that instruction occupies EX, with 1-cycle latency from ID.
REQ-009 Operand A code SHALL be:
- 10 if the current EX record has regwrite, rd!=0 and rd==id_rs_i;
- else 01 if the current MEM record has regwrite, rd!=0 and rd==id_rs_i;
- else 00.
REQ-010 Operand B code SHALL follow the REQ-009 rules using id_rt_i, and SHALL be 00 when id_uses_rt_i=0.
REQ-011 Register 0 SHALL never be forwarded. A simultaneous EX and MEM match SHALL select 10 (newest value wins).
REQ-012 The register file is write-first. A match against the current WB record SHALL NOT be forwarded.
REQ-013 The FSM SHALL have three states: RUN (00), LDSTALL (01) and FREEZE (10).
REQ-014 RUN -> FREEZE SHALL occur when mdu_busy_i=1.
- In FREEZE: stall_o=1, bubble_o=0; records and forward codes hold.
REQ-015 RUN -> LDSTALL SHALL occur on a load-use hazard, defined as:
- id_valid_i=1, flush_i=0;
- the EX record has memread=1 and rd!=0;
- rd==id_rs_i, or (id_uses_rt_i=1 and rd==id_rt_i).
REQ-016 In the hazard cycle, stall_o and bubble_o SHALL be 1 combinationally. Records SHALL advance with a bubble into EX.
REQ-017 LDSTALL SHALL last exactly one cycle.
- stall_o=0; the held ID instruction is re-evaluated and now forwards 01 from the load.
- Next state: RUN, or FREEZE if mdu_busy_i=1.
REQ-018 FREEZE SHALL return to RUN on the first cycle with mdu_busy_i=0. Forward evaluation then resumes from the held records.
REQ-019 Simultaneous events SHALL be prioritised as follows:
- mdu_busy_i beats load-use.
- flush_i suppresses load-use: no stall, ID squashed to a bubble.
- flush_i during FREEZE is ignored until exit.
REQ-020 A load followed by a dependent instruction two slots later SHALL NOT stall. It SHALL forward 01.

Reset
REQ-021 While rst_i=0, asynchronously:
- state=RUN;
- all records cleared (rd=0, regwrite=0, memread=0);
- fwd_a_o=fwd_b_o=00, stall_o=0, bubble_o=0.
REQ-022 Reset asserted mid-LDSTALL or mid-FREEZE SHALL abandon the operation. The first edge after release SHALL behave as RUN with empty records.

Structure
REQ-023 Package hazard_pkg SHALL hold:
- forward code constants FWD_RF, FWD_WB, FWD_MEM;
- state encodings ST_RUN, ST_LDSTALL, ST_FREEZE;
- the stage-record type.
REQ-024 The stage-record register with enable and bubble-clear SHALL be sub-module hazard_stage_reg, instantiated three times.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- add $3 then sub $5,$3,$4 -> sub in EX: fwd_a_o=10, fwd_b_o=00, no stall.
- add $3; nop; or $6,$7,$3 -> or in EX: fwd_b_o=01.
- lw $2; add $4,$2,$2 -> one cycle stall_o=1, bubble_o=1, state 01; add then gets fwd_a_o=fwd_b_o=01.
- Writes to $0 followed by a reader of $0 -> codes stay 00; addi with rt==load rd and id_uses_rt_i=0 -> no stall.
- mdu_busy_i high 3 cycles during a lw-use hazard -> FREEZE 3 cycles, then LDSTALL 1 cycle, then RUN; records held throughout.
- flush_i coincident with a load-use hazard -> no stall, EX record regwrite=0.
- rst_i low during FREEZE -> outputs zero immediately, state 00.
